// File: rtl/vga_text_pkg.sv
// rtl/vga_text_pkg.sv - shared control codes and state encoding for the text writer
package vga_text_pkg;

    localparam logic [7:0] CH_LF    = 8'h0A;
    localparam logic [7:0] CH_CR    = 8'h0D;
    localparam logic [7:0] CH_BS    = 8'h08;
    localparam logic [7:0] CH_FF    = 8'h0C;
    localparam logic [7:0] CH_SPACE = 8'h20;

    typedef enum logic [1:0] {
        IDLE,
        CLEAR_LINE,
        CLEAR_ALL
    } state_t;

endpackage

// File: rtl/vga_text_writer_if.sv
// rtl/vga_text_writer_if.sv - byte stream handshake into the text writer
interface vga_text_writer_if;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;

    modport master (output in_valid, output in_data, input in_ready);
    modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/vga_text_cursor.sv
// rtl/vga_text_cursor.sv - cursor column/row registers with incrementally maintained row base address
module vga_text_cursor #(
    parameter int COLS       = 160,
    parameter int ROWS       = 128,
    parameter int col_width  = $clog2(COLS),
    parameter int row_width  = $clog2(ROWS),
    parameter int addr_width = $clog2(COLS * ROWS)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  advance,
    input  logic                  newline,
    input  logic                  cr,
    input  logic                  bs,
    input  logic                  home,
    output logic [col_width-1:0]  col,
    output logic [row_width-1:0]  row,
    output logic [addr_width-1:0] row_base,
    output logic                  wrap
);

    localparam logic [col_width-1:0]  COL_LAST = col_width'(COLS - 1);
    localparam logic [row_width-1:0]  ROW_LAST = row_width'(ROWS - 1);
    localparam logic [addr_width-1:0] ROW_STEP = addr_width'(COLS);

    // An advance from the last column turns into a row advance
    assign wrap = (col == COL_LAST);

    // Cursor update; row_base tracks row*COLS by add/reset so no multiplier is needed
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col      <= '0;
            row      <= '0;
            row_base <= '0;
        end else if (home) begin
            col      <= '0;
            row      <= '0;
            row_base <= '0;
        end else if (newline || (advance && wrap)) begin
            col <= '0;
            if (row == ROW_LAST) begin
                row      <= '0;
                row_base <= '0;
            end else begin
                row      <= row + 1'b1;
                row_base <= row_base + ROW_STEP;
            end
        end else if (advance) begin
            col <= col + 1'b1;
        end else if (cr) begin
            col <= '0;
        end else if (bs && (col != '0)) begin
            col <= col - 1'b1;
        end
    end

endmodule

// File: rtl/vga_text_writer.sv
// rtl/vga_text_writer.sv - byte stream to text buffer writer with cursor, control codes and clears
module vga_text_writer
    import vga_text_pkg::*;
#(
    parameter int h_disp = 1280,
    parameter int v_disp = 1024,
    localparam int COLS            = h_disp / 8,
    localparam int ROWS            = v_disp / 8,
    localparam int col_width       = $clog2(COLS),
    localparam int row_width       = $clog2(ROWS),
    localparam int char_addr_width = $clog2(h_disp * v_disp / 64)
) (
    input  logic                       clk,
    input  logic                       reset,
    vga_text_writer_if.slave           in_if,
    output logic                       we,
    output logic [char_addr_width-1:0] addr_write,
    output logic [7:0]                 char_write,
    output logic [col_width-1:0]       cursor_col,
    output logic [row_width-1:0]       cursor_row,
    output logic                       busy
);

    localparam logic [char_addr_width-1:0] LINE_LAST = char_addr_width'(COLS - 1);
    localparam logic [char_addr_width-1:0] ALL_LAST  = char_addr_width'(COLS * ROWS - 1);

    state_t                     state;
    logic [char_addr_width-1:0] fill;
    logic                       in_ready_q;
    logic [col_width-1:0]       col;
    logic [row_width-1:0]       row;
    logic [char_addr_width-1:0] row_base;
    logic                       wrap;
    logic [char_addr_width-1:0] cur_addr;
    logic                       accept;
    logic [7:0]                 in_byte;
    logic                       is_print;

    assign in_if.in_ready = in_ready_q;
    assign accept         = in_if.in_valid && in_ready_q;
    assign in_byte        = in_if.in_data;
    assign is_print       = (in_byte >= 8'h20) && (in_byte <= 8'h7E);
    assign cur_addr       = row_base + char_addr_width'(col);
    assign cursor_col     = col;
    assign cursor_row     = row;

    vga_text_cursor #(
        .COLS       (COLS),
        .ROWS       (ROWS),
        .col_width  (col_width),
        .row_width  (row_width),
        .addr_width (char_addr_width)
    ) u_cursor (
        .clk      (clk),
        .rst_n    (reset),
        .advance  (accept && is_print),
        .newline  (accept && (in_byte == CH_LF)),
        .cr       (accept && (in_byte == CH_CR)),
        .bs       (accept && (in_byte == CH_BS)),
        .home     (accept && (in_byte == CH_FF)),
        .col      (col),
        .row      (row),
        .row_base (row_base),
        .wrap     (wrap)
    );

    // Writer FSM: byte interpretation in IDLE, one space per cycle while clearing
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= CLEAR_ALL;
            fill       <= '0;
            we         <= 1'b0;
            addr_write <= '0;
            char_write <= CH_SPACE;
            in_ready_q <= 1'b0;
            busy       <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    we <= 1'b0;
                    if (accept) begin
                        if (is_print) begin
                            we         <= 1'b1;
                            addr_write <= cur_addr;
                            char_write <= in_byte;
                            if (wrap) begin
                                // the cursor's row_base is already on the new row when the clear starts
                                state      <= CLEAR_LINE;
                                fill       <= '0;
                                in_ready_q <= 1'b0;
                                busy       <= 1'b1;
                            end
                        end else if (in_byte == CH_LF) begin
                            state      <= CLEAR_LINE;
                            fill       <= '0;
                            in_ready_q <= 1'b0;
                            busy       <= 1'b1;
                        end else if ((in_byte == CH_BS) && (col != '0)) begin
                            we         <= 1'b1;
                            addr_write <= cur_addr - 1'b1;
                            char_write <= CH_SPACE;
                        end else if (in_byte == CH_FF) begin
                            state      <= CLEAR_ALL;
                            fill       <= '0;
                            in_ready_q <= 1'b0;
                            busy       <= 1'b1;
                        end
                    end
                end
                CLEAR_LINE: begin
                    we         <= 1'b1;
                    addr_write <= row_base + fill;
                    char_write <= CH_SPACE;
                    if (fill == LINE_LAST) begin
                        state      <= IDLE;
                        fill       <= '0;
                        in_ready_q <= 1'b1;
                        busy       <= 1'b0;
                    end else begin
                        fill <= fill + 1'b1;
                    end
                end
                CLEAR_ALL: begin
                    we         <= 1'b1;
                    addr_write <= fill;
                    char_write <= CH_SPACE;
                    if (fill == ALL_LAST) begin
                        state      <= IDLE;
                        fill       <= '0;
                        in_ready_q <= 1'b1;
                        busy       <= 1'b0;
                    end else begin
                        fill <= fill + 1'b1;
                    end
                end
                default: begin
                    state      <= CLEAR_ALL;
                    fill       <= '0;
                    we         <= 1'b0;
                    in_ready_q <= 1'b0;
                    busy       <= 1'b1;
                end
            endcase
        end
    end

endmodule
